// File: rtl/opb_register_simulink2ppc_fifo.sv
// rtl/opb_register_simulink2ppc_fifo.sv - OPB slave that lets the PowerPC read words pushed by fabric logic through a FIFO
module opb_register_simulink2ppc_fifo #(
    parameter logic [31:0] C_BASEADDR    = 32'h01001100,
    parameter logic [31:0] C_HIGHADDR    = 32'h010011FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter int          C_FIFO_AWIDTH = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid,
    output logic                      user_full
);

    localparam int AW = C_FIFO_AWIDTH;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [1:0]    offset;
    logic          hit;
    logic          take;
    logic          is_full;
    logic          is_empty;
    logic [31:0]   status_word;
    logic [31:0]   rd_word;
    logic          push_ok;
    logic          ovf_set;
    logic [AW:0]   count_next;

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic [31:0]   dbus_q;

    // Side effects captured in the hit cycle and committed at the end of the ack cycle
    logic          pend_pop;
    logic          pend_udf;
    logic          pend_clr_ovf;
    logic          pend_clr_udf;
    logic          pend_flush;

    // Vector assignment keeps the big-endian bus bit 0 as our bit 31
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    assign be    = OPB_BE;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_DBus    = dbus_q;

    wire unused_ok = &{1'b0, OPB_seqAddr, be[2:1], wdata[29:1]};

    always_comb begin
        hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
        take     = hit && !Sl_xferAck;
        offset   = addr[3:2];
        is_full  = (count == DEPTH_C);
        is_empty = (count == '0);

        status_word           = 32'h0;
        status_word[31]       = ovf;
        status_word[30]       = udf;
        status_word[29]       = is_full;
        status_word[28]       = is_empty;
        status_word[AW:0]     = count;

        rd_word = 32'h0;
        case (offset)
            2'd0:    rd_word = is_empty ? 32'h0 : mem[rptr];
            2'd1:    rd_word = status_word;
            default: rd_word = 32'h0;
        endcase

        // A pop committing this edge frees the slot a full-FIFO push needs
        push_ok = user_valid && !pend_flush && (!is_full || pend_pop);
        ovf_set = user_valid && !pend_flush && is_full && !pend_pop;

        if (pend_flush)
            count_next = '0;
        else
            count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pend_pop};
    end

    always_ff @(posedge OPB_Clk) begin
        if (push_ok)
            mem[wptr] <= user_data_in;
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            Sl_xferAck   <= 1'b0;
            dbus_q       <= 32'h0;
            user_full    <= 1'b0;
            count        <= '0;
            wptr         <= '0;
            rptr         <= '0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
            pend_pop     <= 1'b0;
            pend_udf     <= 1'b0;
            pend_clr_ovf <= 1'b0;
            pend_clr_udf <= 1'b0;
            pend_flush   <= 1'b0;
        end else begin
            Sl_xferAck   <= take;
            dbus_q       <= (take && OPB_RNW) ? rd_word : 32'h0;

            pend_pop     <= take &&  OPB_RNW && (offset == 2'd0) && !is_empty;
            pend_udf     <= take &&  OPB_RNW && (offset == 2'd0) &&  is_empty;
            pend_clr_ovf <= take && !OPB_RNW && (offset == 2'd1) && be[3] && wdata[31];
            pend_clr_udf <= take && !OPB_RNW && (offset == 2'd1) && be[3] && wdata[30];
            pend_flush   <= take && !OPB_RNW && (offset == 2'd2) && be[0] && wdata[0];

            count     <= count_next;
            user_full <= (count_next == DEPTH_C);

            if (pend_flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push_ok)
                    wptr <= wptr + 1'b1;
                if (pend_pop)
                    rptr <= rptr + 1'b1;
            end

            // Hardware set takes priority over a coincident write-one-to-clear
            ovf <= (ovf && !pend_clr_ovf) || ovf_set;
            udf <= (udf && !pend_clr_udf) || pend_udf;
        end
    end

endmodule

// File: doc/opb_register_simulink2ppc_fifo.md
Name: opb_register_simulink2ppc_fifo

Overview:
- OPB slave that carries data in the opposite direction to the software-to-fabric registers: fabric (Simulink) logic pushes 32-bit words, and the PowerPC reads them over OPB.
- Words are buffered in a shallow FIFO and popped by OPB reads of the DATA register.
- A STATUS register reports fill level and sticky overflow/underflow flags; a CTRL register flushes the FIFO.
- Sits on the OPB bus beside the software-to-fabric registers; the fabric side runs on the same clock as the bus.

Parameters:
C_BASEADDR, 32'h01001100, first byte address of the slave window
C_HIGHADDR, 32'h010011FF, last byte address of the slave window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_FAMILY, "virtex6", target family (informational only)
C_FIFO_AWIDTH, 4, log2 of FIFO depth (depth D = 16)

Ports:
OPB_Clk  in  1  single clock for bus and user side
OPB_Rst  in  1  asynchronous, active-high reset
Sl_DBus  out  [0:31]  read data; Sl_DBus[0] = MSB
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[3] = least-significant byte
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  bus select
OPB_seqAddr  in  1  ignored
user_data_in  in  [31:0]  word to push
user_valid  in  1  push strobe, one word per cycle
user_full  out  1  FIFO full (registered)

Behaviour:
Clock and reset:
- Single clock domain, OPB_Clk.
- Reset is asynchronous and active-high on OPB_Rst.
- Reset values: Sl_xferAck=0, Sl_DBus=0, user_full=0, count=0, read/write pointers=0, ovf=0, udf=0.

Address decode:
- hit = OPB_select && (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
- Register offset = OPB_ABus[28:29] (word index).
- 0 = DATA (read pops), 1 = STATUS, 2 = CTRL, 3 = reserved (reads 0, writes ignored).

Bus handshake:
- Sl_xferAck <= hit && !Sl_xferAck: a registered pulse one cycle after select, never two consecutive cycles.
- Sl_DBus carries read data only in the Sl_xferAck cycle and is 0 at all other times (wired-OR bus).
- Read data is registered from the state as it stood in the hit cycle.
- Side effects (pop, clear, flush) commit on the clock edge that ends the Sl_xferAck cycle.
- Each transfer has exactly one side effect; a select held high across multiple cycles still pops once per ack.

DATA read:
- If count > 0: return the head word, pop, count decrements.
- If count == 0: return 0x00000000, set udf, count stays 0.
- DATA writes are acked and ignored.

STATUS read, value bits:
- [31] ovf
- [30] udf
- [29] full
- [28] empty
- [C_FIFO_AWIDTH:0] count
- all other bits 0

STATUS write (acked):
- Applies only when OPB_BE[0] = 1 (the byte holding bits 31:24).
- Writing 1 to bit 31 clears ovf; writing 1 to bit 30 clears udf.
- Write-one-to-clear; writing 0 has no effect.

CTRL write:
- If BE[3] = 1 and bit0 = 1: flush (pointers and count to 0; flags untouched).
- A push in the same cycle as a flush is discarded.
- CTRL reads return 0.

FIFO:
- Depth 2^C_FIFO_AWIDTH; count is C_FIFO_AWIDTH+1 bits wide.
- Pointers wrap modulo depth.
- Push when user_valid && count < D.
- Push while full: the word is dropped, ovf is set, and the contents are unchanged.
- Simultaneous push and pop: both occur, count unchanged. At full, a push coincident with a pop is accepted and does not set ovf.
- Simultaneous flag set (hardware event) and write-1-clear: set wins.
- user_full = (count == D), registered, valid the cycle after the count change.
- A pushed word is visible to a DATA read whose hit is at least one cycle after the push.

Reset mid-transfer:
- Sl_xferAck drops immediately (asynchronously); the transfer is lost; the FIFO is empty after reset.

Test Plan:
- Reset: assert OPB_Rst mid-ack -> Sl_xferAck=0 and Sl_DBus=0 the same cycle; STATUS read afterwards returns 0x10000000 (empty=1, count=0).
- Push and pop: push 0xDEADBEEF, 0x00000001, 0x12345678 -> STATUS count=3; three DATA reads return those words in order, each acked exactly 1 cycle after select, ack one cycle wide.
- Overflow: push 17 words 0..16 -> user_full=1, STATUS = 0xA0000010; DATA reads return 0..15; write 0x80000000 with BE=1000 to STATUS -> ovf cleared.
- Underflow: DATA read while empty -> returns 0, STATUS bit30=1; STATUS write 0x40000000 with BE=0000 -> no clear.
- Push/pop concurrency at full: FIFO full, DATA read ack coincides with user_valid -> count stays 16, ovf=0, oldest word returned.
- Flush and decode: CTRL write 0x1 (BE=0001) with 5 words queued -> count=0, flags kept; access at C_HIGHADDR+4 -> no ack; OPB_select held 4 cycles on DATA -> acks at cycles 2 and 4 pop exactly two words.
